fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_pkg.sv | 14 +
 rtl/fifo_drain_skid.sv | 66 ++++++
 rtl/fifo_drain.sv | 69 ++++++
 tb/tb_fifo_drain.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO drain blocks.
//   drain_state_e : occupancy of the 2-entry drain buffer (EMPTY/ONE/TWO)
//   DEFAULT_WIDTH : default data word width, matching the upstream FIFO
package fifo_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } drain_state_e;

endpackage

// File: rtl/fifo_drain_skid.sv
// fifo_drain_skid: 2-entry in-order buffer between the FIFO and the consumer.
// Its occupancy is the drain FSM state. The head is a register, so the
// consumer never sees a combinational path from push_data.
//   clk, rst_n : clock and synchronous active-low reset
//   push       : capture push_data at this edge (not honoured when full)
//   push_data  : word to capture
//   pop        : consumer took the head at this edge (ignored when empty)
//   head       : oldest buffered word
//   count      : occupancy (EMPTY / ONE / TWO)
module fifo_drain_skid
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output drain_state_e     count
);

  logic [WIDTH-1:0] tail;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block reads the pre-edge value of every other one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= EMPTY;
      head  <= '0;
      // NOTE: the tail entry is reset as well; it is only two words, and
      // that keeps its contents deterministic after reset.
      tail  <= '0;
    end else begin
      case (count)
        EMPTY: begin
          if (push) begin
            head  <= push_data;
            count <= ONE;
          end
        end
        ONE: begin
          // A simultaneous push and pop replaces the head in place: the old
          // word leaves and the new one becomes the oldest.
          if (push && pop) begin
            head <= push_data;
          end else if (push) begin
            tail  <= push_data;
            count <= TWO;
          end else if (pop) begin
            count <= EMPTY;
          end
        end
        TWO: begin
          if (pop) begin
            head  <= tail;
            count <= ONE;
          end
        end
        default: count <= EMPTY;
      endcase
    end
  end

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: pops words out of a FIFO whose empty flag is registered and
// presents them downstream on a valid/ready interface, in pop order.
// Optional feature macro: FIFO_DRAIN_CNT_EN adds the saturating drain_cnt.
//   clk, rst_n : clock and synchronous active-low reset
//   drain_en   : permits popping the FIFO
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO read data, valid in a cycle where fifo_pop=1
//   fifo_pop   : pop request to the FIFO (combinational)
//   m_valid    : downstream word valid
//   m_ready    : downstream accepts the word
//   m_data     : downstream word (registered)
//   drain_cnt  : words delivered, saturating (FIFO_DRAIN_CNT_EN only)
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             drain_en,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             fifo_pop,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
`ifdef FIFO_DRAIN_CNT_EN
  ,
  output logic [CNT_W-1:0] drain_cnt
`endif
);

  drain_state_e state;
  logic         xfer;

  // Pop only when the buffer has room; gating with rst_n keeps the FIFO
  // untouched while reset is held.
  assign fifo_pop = drain_en & ~fifo_empty & (state != TWO) & rst_n;
  assign m_valid  = (state != EMPTY);
  assign xfer     = m_valid & m_ready;

  fifo_drain_skid #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_pop),
    .push_data(fifo_data),
    .pop      (xfer),
    .head     (m_data),
    .count    (state)
  );

`ifdef FIFO_DRAIN_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drain_cnt <= '0;
    end else if (xfer && (drain_cnt != {CNT_W{1'b1}})) begin
      drain_cnt <= drain_cnt + 1'b1;
    end
  end
`else
  // Counter absent; CNT_W is kept only so the parameter list is the same
  // in both builds.
  localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_fifo_drain.sv
// tb_fifo_drain: directed scenarios plus a randomized phase for fifo_drain.
// The upstream FIFO and the expected downstream behaviour are modelled with
// queues: a word leaves the FIFO when the buffer (at most two words) has
// room, and the oldest buffered word is offered downstream.
module tb_fifo_drain;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk;
  logic             rst_n;
  logic             drain_en;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_pop;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;
`ifdef FIFO_DRAIN_CNT_EN
  logic [CNT_W-1:0] drain_cnt;
`endif

  fifo_drain #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .drain_en  (drain_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_pop  (fifo_pop),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data)
`ifdef FIFO_DRAIN_CNT_EN
    ,
    .drain_cnt (drain_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [WIDTH-1:0] fifo_q[$];     // upstream FIFO contents
  logic [WIDTH-1:0] buf_q[$];      // words held inside the drain block
  logic [WIDTH-1:0] exp_deliv[$];  // words that should reach downstream
  logic [WIDTH-1:0] got_deliv[$];  // words seen leaving the DUT
  int               exp_cnt;
  bit               data_known;
  logic [WIDTH-1:0] data_idle;     // m_data expected while the buffer is empty
  bit               exp_pop;
  bit               exp_valid;
  bit               exp_xfer;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? WIDTH'($urandom) : fifo_q[0];
  endtask

  // One clock: compare at the falling edge, advance the model after the
  // rising edge.
  task automatic tick();
    refresh_fifo();
    @(negedge clk);
    exp_pop   = rst_n && drain_en && (fifo_q.size() > 0) && (buf_q.size() < 2);
    exp_valid = (buf_q.size() > 0);
    exp_xfer  = rst_n && exp_valid && m_ready;
    check("fifo_pop", 32'(fifo_pop), 32'(exp_pop));
    check("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) check("m_data", 32'(m_data), 32'(buf_q[0]));
    else if (data_known) check("m_data_idle", 32'(m_data), 32'(data_idle));
`ifdef FIFO_DRAIN_CNT_EN
    check("drain_cnt", 32'(drain_cnt), 32'(exp_cnt));
`endif
    if (rst_n && m_valid && m_ready) got_deliv.push_back(m_data);
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) begin
      buf_q.delete();
      exp_cnt    = 0;
      data_known = 1'b1;
      data_idle  = '0;
    end else begin
      if (exp_xfer) begin
        exp_deliv.push_back(buf_q.pop_front());
        if (exp_cnt < (1 << CNT_W) - 1) exp_cnt++;
      end
      if (exp_pop) buf_q.push_back(fifo_q.pop_front());
      if (exp_xfer || exp_pop) data_known = (buf_q.size() > 0);
    end
    refresh_fifo();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    drain_en   = 1'b0;
    m_ready    = 1'b0;
    exp_cnt    = 0;
    data_known = 1'b0;
    data_idle  = '0;
    refresh_fifo();
    // First edge brings the DUT out of its unknown power-up state.
    @(posedge clk);
    #1;
    data_known = 1'b1;
    do_reset();
    tick();

    // Three words, consumer always ready: one word per cycle, one cycle
    // after each pop.
    fifo_q   = '{8'h11, 8'h22, 8'h33};
    drain_en = 1'b1;
    m_ready  = 1'b1;
    repeat (5) tick();

    // Five words, consumer stalled: two pops then hold with word 0 stable.
    fifo_q  = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    m_ready = 1'b0;
    repeat (5) tick();
    check("stall_fifo_left", 32'(fifo_q.size()), 32'd3);
    m_ready = 1'b1;
    repeat (6) tick();

    // Empty FIFO throughout while the controls toggle.
    for (int i = 0; i < 8; i++) begin
      drain_en = i[0];
      m_ready  = i[1];
      tick();
    end

    // One word buffered, then a pop and a transfer in the same cycle.
    drain_en = 1'b1;
    m_ready  = 1'b0;
    fifo_q   = '{8'h5A};
    tick();
    fifo_q.push_back(8'h6B);
    m_ready = 1'b1;
    tick();
    check("pop_xfer_buf_size", 32'(buf_q.size()), 32'd1);
    repeat (2) tick();

    // Reset while two words are buffered, then a fresh word 0xA5.
    m_ready = 1'b0;
    fifo_q  = '{8'h71, 8'h72, 8'h73};
    repeat (3) tick();
    do_reset();
    fifo_q  = '{8'hA5};
    m_ready = 1'b1;
    repeat (3) tick();

    // Randomized traffic, with occasional resets.
    for (int i = 0; i < 300; i++) begin
      drain_en = ($urandom_range(0, 3) != 0);
      m_ready  = ($urandom_range(0, 2) != 0);
      rst_n    = ($urandom_range(0, 59) != 0);
      if (($urandom_range(0, 1) == 0) && (fifo_q.size() < 8))
        fifo_q.push_back(WIDTH'($urandom));
      tick();
    end
    rst_n    = 1'b1;
    drain_en = 1'b1;
    m_ready  = 1'b1;
    repeat (12) tick();

    // Delivered stream as a whole: order, no loss, no duplication.
    check("deliv_count", 32'(got_deliv.size()), 32'(exp_deliv.size()));
    for (int i = 0; i < exp_deliv.size() && i < got_deliv.size(); i++)
      check("deliv_word", 32'(got_deliv[i]), 32'(exp_deliv[i]));

`ifdef FIFO_DRAIN_CNT_EN
    // Counter saturates after 20 transfers with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 20; i++) fifo_q.push_back(WIDTH'(i + 1));
    repeat (24) tick();
    check("cnt_saturated", 32'(drain_cnt), 32'd15);
    repeat (3) tick();
    check("cnt_held", 32'(drain_cnt), 32'd15);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
